// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the serial execution unit and its decoder.
//   - aluControl code constants (ALU_ADD .. ALU_CMPGEU)
//   - FSM state type of alu_serial_exec
//   - shift-mode type used by alu_shift_step
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_SLL    = 4'h2;
  localparam logic [3:0] ALU_SLT    = 4'h3;
  localparam logic [3:0] ALU_SLTU   = 4'h4;
  localparam logic [3:0] ALU_XOR    = 4'h5;
  localparam logic [3:0] ALU_SRA    = 4'h6;
  localparam logic [3:0] ALU_SRL    = 4'h7;
  localparam logic [3:0] ALU_OR     = 4'h8;
  localparam logic [3:0] ALU_AND    = 4'h9;
  localparam logic [3:0] ALU_CMPEQ  = 4'hA;
  localparam logic [3:0] ALU_CMPNE  = 4'hB;
  localparam logic [3:0] ALU_CMPGE  = 4'hC;
  localparam logic [3:0] ALU_CMPGEU = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_t;

  typedef enum logic [1:0] {
    SHIFT_LEFT,
    SHIFT_RIGHT_LOGIC,
    SHIFT_RIGHT_ARITH
  } shift_mode_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic shift_mode_t shift_mode_of(input logic [3:0] code);
    case (code)
      ALU_SRA: return SHIFT_RIGHT_ARITH;
      ALU_SRL: return SHIFT_RIGHT_LOGIC;
      default: return SHIFT_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_exec_if.sv
// alu_serial_exec_if: request/response bundle of alu_serial_exec.
//   Request : inValid/inReady handshake, aluControl, opA, opB, flush
//   Response: outValid/outReady handshake, result, cmpOut, zero
//   master = requester/consumer side, slave = execution unit side.
interface alu_serial_exec_if #(
  parameter int unsigned XLEN = 32
);
  logic            inValid;
  logic            inReady;
  logic [3:0]      aluControl;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            flush;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] result;
  logic            cmpOut;
  logic            zero;

  modport master (
    output inValid, aluControl, opA, opB, flush, outReady,
    input  inReady, outValid, result, cmpOut, zero
  );

  modport slave (
    input  inValid, aluControl, opA, opB, flush, outReady,
    output inReady, outValid, result, cmpOut, zero
  );
endinterface

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational shift of data_in by k (0..SHIFT_STEP) positions.
//   data_in  in  XLEN  value to shift
//   k        in  KW    shift distance
//   mode     in        left / logical right / arithmetic right
//   data_out out XLEN  shifted value
module alu_shift_step
  import alu_pkg::*;
#(
  parameter  int unsigned XLEN       = 32,
  parameter  int unsigned SHIFT_STEP = 1,
  localparam int unsigned KW         = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0] data_in,
  input  logic [KW-1:0]   k,
  input  shift_mode_t     mode,
  output logic [XLEN-1:0] data_out
);
  always_comb begin
    data_out = data_in;
    case (mode)
      SHIFT_LEFT:        data_out = data_in << k;
      SHIFT_RIGHT_LOGIC: data_out = data_in >> k;
      SHIFT_RIGHT_ARITH: data_out = $signed(data_in) >>> k;
      default:           data_out = data_in;
    endcase
  end
endmodule

// File: rtl/alu_serial_exec.sv
// alu_serial_exec: multi-cycle ALU behind valid/ready handshakes.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of alu_serial_exec_if (request, response, flush)
// Shifts are iterated SHIFT_STEP bits per cycle through alu_shift_step.
// Define ALU_SERIAL_BARREL_EN to build a one-cycle barrel shift instead
// (no SHIFT state, SHIFT_STEP ignored).
module alu_serial_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu_serial_exec_if.slave bus
);
  localparam int unsigned SW = $clog2(XLEN);
`ifdef ALU_SERIAL_BARREL_EN
  localparam int unsigned STEP_W = XLEN - 1;
`else
  localparam int unsigned STEP_W = SHIFT_STEP;
`endif
  localparam int unsigned KW = $clog2(STEP_W + 1);

  alu_state_t      state;
  logic [XLEN-1:0] result_q;
  logic            cmp_q;

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sh_in;
  logic [XLEN-1:0] sh_out;
  logic [KW-1:0]   sh_k;
  shift_mode_t     sh_mode;
  logic [XLEN-1:0] alu_res;
  logic            alu_cmp;

  assign shamt = bus.opB[SW-1:0];

`ifdef ALU_SERIAL_BARREL_EN
  assign sh_in   = bus.opA;
  assign sh_k    = KW'(shamt);
  assign sh_mode = shift_mode_of(bus.aluControl);
`else
  logic [XLEN-1:0] work;
  logic [SW-1:0]   cnt;
  logic [SW-1:0]   cnt_next;
  shift_mode_t     mode_q;
  logic [31:0]     k_ext;

  // k = min(SHIFT_STEP, remaining), widened so SHIFT_STEP == XLEN still compares.
  always_comb begin
    k_ext = 32'(cnt);
    if (k_ext > SHIFT_STEP) k_ext = SHIFT_STEP;
  end

  assign sh_k     = KW'(k_ext);
  assign cnt_next = cnt - SW'(k_ext);
  assign sh_in    = work;
  assign sh_mode  = mode_q;
`endif

  alu_shift_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (STEP_W)
  ) u_shift (
    .data_in  (sh_in),
    .k        (sh_k),
    .mode     (sh_mode),
    .data_out (sh_out)
  );

  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    case (bus.aluControl)
      ALU_ADD:  alu_res = bus.opA + bus.opB;
      ALU_SUB:  alu_res = bus.opA - bus.opB;
      ALU_SLT: begin
        alu_cmp = $signed(bus.opA) < $signed(bus.opB);
        alu_res = {{(XLEN-1){1'b0}}, alu_cmp};
      end
      ALU_SLTU: begin
        alu_cmp = bus.opA < bus.opB;
        alu_res = {{(XLEN-1){1'b0}}, alu_cmp};
      end
      ALU_XOR:  alu_res = bus.opA ^ bus.opB;
      ALU_OR:   alu_res = bus.opA | bus.opB;
      ALU_AND:  alu_res = bus.opA & bus.opB;
`ifdef ALU_SERIAL_BARREL_EN
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = sh_out;
`else
      // Only the shamt==0 case completes from IDLE; real shifts go through SHIFT.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.opA;
`endif
      ALU_CMPEQ:  alu_cmp = bus.opA == bus.opB;
      ALU_CMPNE:  alu_cmp = bus.opA != bus.opB;
      ALU_CMPGE:  alu_cmp = $signed(bus.opA) >= $signed(bus.opB);
      ALU_CMPGEU: alu_cmp = bus.opA >= bus.opB;
      default: begin
        alu_res = '0;
        alu_cmp = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result_q <= '0;
      cmp_q    <= 1'b0;
`ifndef ALU_SERIAL_BARREL_EN
      work     <= '0;
      cnt      <= '0;
      mode_q   <= SHIFT_LEFT;
`endif
    end else if (bus.flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.inValid) begin
`ifndef ALU_SERIAL_BARREL_EN
            if (is_shift(bus.aluControl) && (shamt != '0)) begin
              state  <= ST_SHIFT;
              work   <= bus.opA;
              cnt    <= shamt;
              mode_q <= shift_mode_of(bus.aluControl);
            end else
`endif
            begin
              state    <= ST_DONE;
              result_q <= alu_res;
              cmp_q    <= alu_cmp;
            end
          end
        end
`ifndef ALU_SERIAL_BARREL_EN
        ST_SHIFT: begin
          work <= sh_out;
          cnt  <= cnt_next;
          if (cnt_next == '0) begin
            state    <= ST_DONE;
            result_q <= sh_out;
            cmp_q    <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (bus.outReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.inReady  = (state == ST_IDLE);
  assign bus.outValid = (state == ST_DONE);
  assign bus.result   = result_q;
  assign bus.cmpOut   = cmp_q;
  assign bus.zero     = (result_q == '0);

endmodule

// File: tb/tb_alu_serial_exec.sv
// tb_alu_serial_exec: drives two alu_serial_exec instances (SHIFT_STEP 1 and 4)
// with identical requests and checks results, flags and latencies against a
// behavioural model.
module tb_alu_serial_exec;
  logic clk;
  logic rst_n;

  alu_serial_exec_if #(.XLEN(32)) bus1 ();
  alu_serial_exec_if #(.XLEN(32)) bus4 ();

  alu_serial_exec #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  alu_serial_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model from the operation table, plain arithmetic.
  task automatic ref_alu(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c);
    int unsigned sh;
    sh = int'(b[4:0]);
    r = 32'h0;
    c = 1'b0;
    case (code)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a << sh;
      4'h3: begin c = ($signed(a) < $signed(b)); r = {31'h0, c}; end
      4'h4: begin c = (a < b); r = {31'h0, c}; end
      4'h5: r = a ^ b;
      4'h6: r = a[31] ? ~((~a) >> sh) : (a >> sh);
      4'h7: r = a >> sh;
      4'h8: r = a | b;
      4'h9: r = a & b;
      4'hA: c = (a == b);
      4'hB: c = (a != b);
      4'hC: c = ($signed(a) >= $signed(b));
      4'hD: c = (a >= b);
      default: begin r = 32'h0; c = 1'b0; end
    endcase
  endtask

  function automatic int exp_lat(input int step, input logic [3:0] code, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
`ifdef ALU_SERIAL_BARREL_EN
    return 1;
`else
    if ((code == 4'h2 || code == 4'h6 || code == 4'h7) && s != 0)
      return 1 + (s + step - 1) / step;
    return 1;
`endif
  endfunction

  task automatic drive_req(input logic v, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    bus1.inValid = v; bus1.aluControl = code; bus1.opA = a; bus1.opB = b;
    bus4.inValid = v; bus4.aluControl = code; bus4.opA = a; bus4.opB = b;
  endtask

  task automatic drive_ctl(input logic fl, input logic ordy);
    bus1.flush = fl; bus1.outReady = ordy;
    bus4.flush = fl; bus4.outReady = ordy;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_inReady1"},  32'(bus1.inReady),  32'd1);
    check({tag, "_outValid1"}, 32'(bus1.outValid), 32'd0);
    check({tag, "_result1"},   bus1.result,        32'd0);
    check({tag, "_cmpOut1"},   32'(bus1.cmpOut),   32'd0);
    check({tag, "_zero1"},     32'(bus1.zero),     32'd1);
    check({tag, "_inReady4"},  32'(bus4.inReady),  32'd1);
    check({tag, "_outValid4"}, 32'(bus4.outValid), 32'd0);
    check({tag, "_result4"},   bus4.result,        32'd0);
  endtask

  // Issue one request on both units; check latency, outputs, stability while
  // outReady is held low (optionally offering a new request), then retire it.
  task automatic do_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit poke);
    logic [31:0] er;
    logic        ec;
    int lat1, lat4;
    ref_alu(code, a, b, er, ec);
    drive_req(1'b1, code, a, b);
    @(posedge clk); #1;
    drive_req(1'b0, 4'($urandom), $urandom, $urandom);
    check({tag, "_acc_inReady1"}, 32'(bus1.inReady), 32'd0);
    lat1 = 0;
    lat4 = 0;
    for (int n = 1; n <= 80; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (bus1.outValid && lat1 == 0) lat1 = n;
      if (bus4.outValid && lat4 == 0) lat4 = n;
      if (lat1 != 0 && lat4 != 0) break;
    end
    check({tag, "_lat1"}, 32'(lat1), 32'(exp_lat(1, code, b)));
    check({tag, "_lat4"}, 32'(lat4), 32'(exp_lat(4, code, b)));
    check({tag, "_result1"}, bus1.result,      er);
    check({tag, "_cmpOut1"}, 32'(bus1.cmpOut), 32'(ec));
    check({tag, "_zero1"},   32'(bus1.zero),   32'(er == 32'h0));
    check({tag, "_result4"}, bus4.result,      er);
    check({tag, "_cmpOut4"}, 32'(bus4.cmpOut), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      if (poke) drive_req(1'b1, 4'h0, $urandom, $urandom);
      @(posedge clk); #1;
      check({tag, "_hold_result1"},   bus1.result,        er);
      check({tag, "_hold_outValid1"}, 32'(bus1.outValid), 32'd1);
      check({tag, "_hold_inReady1"},  32'(bus1.inReady),  32'd0);
      check({tag, "_hold_result4"},   bus4.result,        er);
    end
    drive_req(1'b0, 4'h0, 32'h0, 32'h0);
    drive_ctl(1'b0, 1'b1);
    @(posedge clk); #1;
    drive_ctl(1'b0, 1'b0);
    check({tag, "_ret_outValid1"}, 32'(bus1.outValid), 32'd0);
    check({tag, "_ret_inReady1"},  32'(bus1.inReady),  32'd1);
    check({tag, "_ret_outValid4"}, 32'(bus4.outValid), 32'd0);
    check({tag, "_ret_inReady4"},  32'(bus4.inReady),  32'd1);
  endtask

  initial begin
    logic [3:0]  code;
    logic [31:0] a, b;
    bit          seen;

    rst_n = 1'b0;
    drive_req(1'b0, 4'h0, 32'h0, 32'h0);
    drive_ctl(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_idle_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op("add_wrap", 4'h0, 32'h7FFF_FFFF, 32'h1, 0, 0);
    check("add_wrap_const", bus1.result, 32'h8000_0000);
    do_op("sub_zero", 4'h1, 32'd5, 32'd5, 1, 0);
    do_op("eq",       4'hA, 32'd5, 32'd5, 0, 0);
    do_op("ne",       4'hB, 32'd5, 32'd5, 0, 0);
    do_op("sra31",    4'h6, 32'h8000_0000, 32'd31, 0, 0);
    check("sra31_const", bus1.result, 32'hFFFF_FFFF);
    do_op("slt",      4'h3, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op("sltu",     4'h4, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op("geu",      4'hD, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op("ge_neg",   4'hC, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op("sll0",     4'h2, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0, 0);
    do_op("sll5",     4'h2, 32'hDEAD_BEEF, 32'd5, 0, 0);
    do_op("srl4",     4'h7, 32'hF000_000F, 32'd4, 0, 0);
    do_op("resE",     4'hE, 32'h1234_5678, 32'h1, 0, 0);
    do_op("resF",     4'hF, 32'h1234_5678, 32'h1, 0, 0);
    do_op("backpr",   4'h5, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5, 1);

    // Flush on the third cycle of a 31-bit srl
    drive_req(1'b1, 4'h7, 32'hFFFF_FFFF, 32'd31);
    @(posedge clk); #1;
    drive_req(1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive_ctl(1'b1, 1'b0);
    @(posedge clk); #1;
    drive_ctl(1'b0, 1'b0);
    check("flush_inReady1",  32'(bus1.inReady),  32'd1);
    check("flush_outValid1", 32'(bus1.outValid), 32'd0);
    check("flush_inReady4",  32'(bus4.inReady),  32'd1);
    check("flush_outValid4", 32'(bus4.outValid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus1.outValid || bus4.outValid) seen = 1'b1;
    end
    check("flush_no_outValid", 32'(seen), 32'd0);

    // Flush offered together with a request: nothing accepted
    drive_req(1'b1, 4'h0, 32'd1, 32'd2);
    drive_ctl(1'b1, 1'b0);
    @(posedge clk); #1;
    drive_req(1'b0, 4'h0, 32'h0, 32'h0);
    drive_ctl(1'b0, 1'b0);
    check("flush_vs_req_inReady1", 32'(bus1.inReady), 32'd1);
    check("flush_vs_req_outValid1", 32'(bus1.outValid), 32'd0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      do_op($sformatf("rnd%0d", i), code, a, b, int'($urandom_range(0, 2)), 0);
    end

    // Asynchronous reset in the middle of a shift
    do_op("pre_rst", 4'h6, 32'h8000_0000, 32'd3, 0, 0);
    drive_req(1'b1, 4'h6, 32'h8000_0000, 32'd31);
    @(posedge clk); #1;
    drive_req(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst", 4'h1, 32'd3, 32'd10, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
